// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue controller for the ALU.
// Handles one instruction at a time through FETCH, WAIT, DECODE, EXEC and WB.
// It owns the PC and the F1/F2 flags, and it drives the register-file strobes.
// FAULT (fetch timeout) and HALT (op 127) are sticky until reset.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [6:0]  instr,
    output logic [15:0] value,
    output logic        highlow,
    output logic        alu_en,
    output logic [3:0]  rd_addr_a,
    output logic [3:0]  rd_addr_b,
    output logic [3:0]  wr_addr,
    output logic        wr_en,
    input  logic        f3_in,
    input  logic        addrch_in,
    input  logic [31:0] naddr_in,
    output logic        f1,
    output logic        f2,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault,
    output logic        illegal
);

    localparam int unsigned OP_W   = 7;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_HIGHLOW = 7'd6;
    localparam logic [OP_W-1:0] OP_HALT    = 7'd127;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    // Opcodes 16..126 are undefined; they behave as a NOP that still advances the PC.
    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op >= 7'd16) && (op <= 7'd126);
    endfunction

    // Opcodes 0..7 write back to the register file.
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return op <= 7'd7;
    endfunction

    // Opcodes 8..13 shift the condition result into the flag pair.
    function automatic logic op_updates_flags(input logic [OP_W-1:0] op);
        return (op >= 7'd8) && (op <= 7'd13);
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_W-1:0]  pc_q;
    logic               f1_q, f2_q;
    logic [OP_W-1:0]    op_q;
    logic [IMM_W-1:0]   imm_q;
    logic [REG_W-1:0]   rd_q, ra_q, rb_q;
    logic               highlow_q;

    logic               f3_s_q;
    logic               addrch_s_q;
    logic [ADDR_W-1:0]  naddr_s_q;

    logic               req_q, req_d;
    logic               alu_en_q, alu_en_d;
    logic               wr_en_q, wr_en_d;
    logic               illegal_q, illegal_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    logic               fetch_done;
    logic [CNT_W-1:0]   timeout_last;

    assign fetch_done   = (state_q == ST_WAIT) && imem_ack;
    assign timeout_last = CNT_W'(TIMEOUT - 8'd1);

    // State and wait-counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, including the fetch timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_FETCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The counter holds the number of wait cycles already spent,
                // so an ack on the TIMEOUT-th cycle still wins over the fault.
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (cnt_q == timeout_last) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 8'd1);
                end
            end
            ST_DECODE: begin
                if (op_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (op_is_illegal(op_q)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Output decode, evaluated on the upcoming state so that registered outputs line up with it.
    always_comb begin
        req_d     = 1'b0;
        alu_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        illegal_d = 1'b0;
        halted_d  = 1'b0;
        fault_d   = 1'b0;
        unique case (state_d)
            ST_FETCH:  req_d    = 1'b1;
            ST_WAIT:   req_d    = 1'b1;
            ST_EXEC:   alu_en_d = 1'b1;
            ST_WB:     wr_en_d  = op_writes_reg(op_q);
            ST_HALT:   halted_d = 1'b1;
            ST_FAULT:  fault_d  = 1'b1;
            default:   req_d    = 1'b0;
        endcase
        // The illegal pulse coincides with the DECODE cycle of the offending word.
        illegal_d = fetch_done && op_is_illegal(imem_data[6:0]);
    end

    // Registered strobes and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q     <= 1'b0;
            alu_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            req_q     <= req_d;
            alu_en_q  <= alu_en_d;
            wr_en_q   <= wr_en_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    // The instruction latch doubles as the decoded ALU/register-file drive, which is stable from DECODE through WB.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            highlow_q <= 1'b0;
        end else if (fetch_done) begin
            op_q      <= imem_data[6:0];
            imm_q     <= imem_data[31:16];
            rd_q      <= imem_data[10:7];
            ra_q      <= imem_data[14:11];
            rb_q      <= imem_data[18:15];
            highlow_q <= (imem_data[6:0] == OP_HIGHLOW);
        end
    end

    // ALU result capture at the end of EXEC; the branch flag is cleared in DECODE so that a skipped EXEC cannot branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            f3_s_q     <= 1'b0;
            addrch_s_q <= 1'b0;
            naddr_s_q  <= '0;
        end else if (state_q == ST_EXEC) begin
            f3_s_q     <= f3_in;
            addrch_s_q <= addrch_in;
            naddr_s_q  <= naddr_in;
        end else if (state_q == ST_DECODE) begin
            addrch_s_q <= 1'b0;
        end
    end

    // PC and flag update at the end of write-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
            f1_q <= 1'b0;
            f2_q <= 1'b0;
        end else if (state_q == ST_WB) begin
            if (addrch_s_q) begin
                pc_q <= naddr_s_q;
            end else begin
                pc_q <= ADDR_W'(pc_q + PC_STEP);
            end
            if (op_updates_flags(op_q)) begin
                f2_q <= f1_q;
                f1_q <= f3_s_q;
            end
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign instr     = op_q;
    assign value     = imm_q;
    assign highlow   = highlow_q;
    assign rd_addr_a = ra_q;
    assign rd_addr_b = rb_q;
    assign wr_addr   = rd_q;
    assign alu_en    = alu_en_q;
    assign wr_en     = wr_en_q;
    assign illegal   = illegal_q;
    assign f1        = f1_q;
    assign f2        = f2_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random instructions checked against an
// instruction-level reference model (PC, flags, expected strobes per opcode class).
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [6:0]  instr;
    logic [15:0] value;
    logic        highlow;
    logic        alu_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [3:0]  wr_addr;
    logic        wr_en;
    logic        f3_in;
    logic        addrch_in;
    logic [31:0] naddr_in;
    logic        f1;
    logic        f2;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;
    logic        illegal;

    instr_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .instr     (instr),
        .value     (value),
        .highlow   (highlow),
        .alu_en    (alu_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .f3_in     (f3_in),
        .addrch_in (addrch_in),
        .naddr_in  (naddr_in),
        .f1        (f1),
        .f2        (f2),
        .pc_out    (pc_out),
        .halted    (halted),
        .fault     (fault),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state at instruction granularity.
    logic [31:0] mpc;
    logic        mf1;
    logic        mf2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [15:0] imm);
        logic [31:0] w;
        w = {imm, 16'h0000};
        w[6:0]   = op;
        w[10:7]  = rd;
        w[14:11] = ra;
        w[18:15] = rb;
        return w;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        f3_in     = 1'b0;
        addrch_in = 1'b0;
        naddr_in  = 32'h0;
        tick();
        tick();
        chk("rst_req",     32'(imem_req), 32'd0);
        chk("rst_pc",      pc_out,        32'd0);
        chk("rst_strobes", {28'd0, alu_en, wr_en, illegal, halted}, 32'd0);
        chk("rst_fault",   32'(fault),    32'd0);
        chk("rst_flags",   {30'd0, f1, f2}, 32'd0);
        chk("rst_instr",   32'(instr),    32'd0);
        reset = 1'b0;
        mpc   = 32'd0;
        mf1   = 1'b0;
        mf2   = 1'b0;
    endtask

    // Issue one instruction word and check decode, strobes, latency and architectural state.
    task automatic run_instr(input logic [31:0] word, input int delay, input logic f3,
                             input logic ac, input logic [31:0] na);
        logic [6:0] op;
        bit   ok;
        bit   legal;
        bit   bad;
        int   cyc;
        int   alu_n;
        int   wr_n;
        int   ill_n;
        int   both_n;
        int   alu_at;
        int   wr_at;
        op        = word[6:0];
        legal     = (op <= 7'd15);
        bad       = (op >= 7'd16) && (op <= 7'd126);
        f3_in     = f3;
        addrch_in = ac;
        naddr_in  = na;

        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("fetch_seen", 32'(ok), 32'd1);
        chk("fetch_addr", imem_addr, mpc);

        repeat (delay) tick();
        imem_ack  = 1'b1;
        imem_data = word;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!imem_req) begin
                ok = 1'b1;
                break;
            end
        end
        imem_ack  = 1'b0;
        imem_data = $urandom();
        chk("ack_taken", 32'(ok), 32'd1);

        chk("dec_instr",   32'(instr),     32'(op));
        chk("dec_value",   32'(value),     32'(word[31:16]));
        chk("dec_highlow", 32'(highlow),   32'(op == 7'd6));
        chk("dec_ra",      32'(rd_addr_a), 32'(word[14:11]));
        chk("dec_rb",      32'(rd_addr_b), 32'(word[18:15]));
        chk("dec_rd",      32'(wr_addr),   32'(word[10:7]));

        cyc = 0; alu_n = 0; wr_n = 0; ill_n = 0; both_n = 0; alu_at = -1; wr_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (alu_en) begin
                alu_n++;
                alu_at = cyc;
            end
            if (wr_en) begin
                wr_n++;
                wr_at = cyc;
                chk("wb_wr_addr", 32'(wr_addr), 32'(word[10:7]));
            end
            if (illegal) ill_n++;
            if (alu_en && wr_en) both_n++;
            tick();
            cyc++;
            if (imem_req || halted || fault) break;
        end

        chk("alu_count", 32'(alu_n), legal ? 32'd1 : 32'd0);
        chk("alu_cycle", 32'(alu_at), legal ? 32'd1 : 32'hFFFF_FFFF);
        chk("wr_count",  32'(wr_n),  (op <= 7'd7) ? 32'd1 : 32'd0);
        chk("wr_cycle",  32'(wr_at), (op <= 7'd7) ? 32'd2 : 32'hFFFF_FFFF);
        chk("ill_count", 32'(ill_n), bad ? 32'd1 : 32'd0);
        chk("alu_wr_overlap", 32'(both_n), 32'd0);

        if (op == 7'd127) begin
            chk("halt_lat", 32'(cyc),    32'd1);
            chk("halted",   32'(halted), 32'd1);
            chk("halt_pc",  pc_out,      mpc);
        end else begin
            if (legal && ac) mpc = na;
            else             mpc = mpc + 32'd1;
            if (op >= 7'd8 && op <= 7'd13) begin
                mf2 = mf1;
                mf1 = f3;
            end
            chk("latency",   32'(cyc), legal ? 32'd3 : 32'd2);
            chk("next_addr", imem_addr, mpc);
            chk("pc_out",    pc_out,    mpc);
            chk("flags",     {30'd0, f1, f2}, {30'd0, mf1, mf2});
            chk("no_fault",  32'(fault), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   badc;
        logic [6:0] op;
        do_reset();

        // Basic op0 with immediate ack.
        run_instr(mk(7'd0, 4'd1, 4'd2, 4'd3, 16'h1234), 0, 1'b0, 1'b0, 32'h0);
        chk("t1_addr", imem_addr, 32'd1);

        // Flag shift: f3=1 then f3=0.
        run_instr(mk(7'd8, 4'd0, 4'd4, 4'd5, 16'h0001), 1, 1'b1, 1'b0, 32'h0);
        run_instr(mk(7'd8, 4'd0, 4'd4, 4'd5, 16'h0002), 0, 1'b0, 1'b0, 32'h0);
        chk("t2_f1", 32'(f1), 32'd0);
        chk("t2_f2", 32'(f2), 32'd1);

        // Branch taken and not taken.
        run_instr(mk(7'd14, 4'd2, 4'd3, 4'd4, 16'h0000), 0, 1'b0, 1'b1, 32'h40);
        chk("t3_taken", imem_addr, 32'h40);
        run_instr(mk(7'd14, 4'd2, 4'd3, 4'd4, 16'h0000), 2, 1'b1, 1'b0, 32'h99);
        chk("t3_seq", imem_addr, 32'h41);

        // Highlow opcode, then an undefined opcode.
        run_instr(mk(7'd6, 4'd7, 4'd8, 4'd9, 16'hBEEF), 3, 1'b0, 1'b0, 32'h0);
        run_instr(mk(7'h20, 4'd5, 4'd6, 4'd7, 16'h5555), 0, 1'b1, 1'b1, 32'h1234);

        // Randomized instruction stream, mostly defined opcodes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) op = 7'($urandom_range(0, 15));
            else                          op = 7'($urandom_range(16, 126));
            run_instr(mk(op, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)),
                      int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom());
        end

        // PC wrap at the top of the address space.
        run_instr(mk(7'd14, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wrap_top", imem_addr, 32'hFFFF_FFFF);
        run_instr(mk(7'd3, 4'd1, 4'd1, 4'd1, 16'h0), 1, 1'b0, 1'b0, 32'h0);
        chk("wrap_zero", imem_addr, 32'h0);

        // Reset asserted mid-WAIT abandons the fetch.
        run_instr(mk(7'd9, 4'd0, 4'd0, 4'd0, 16'h0), 0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        chk("mid_wait_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_pc",    pc_out, 32'd0);
        chk("mid_rst_req",   32'(imem_req), 32'd0);
        chk("mid_rst_f1",    32'(f1), 32'd0);
        chk("mid_rst_strb",  {29'd0, alu_en, wr_en, illegal}, 32'd0);
        do_reset();

        // Ack on the last permitted wait cycle is accepted.
        run_instr(mk(7'd1, 4'd3, 4'd2, 4'd1, 16'h0F0F), 254, 1'b0, 1'b0, 32'h0);

        // Fetch timeout with the ack withheld.
        do_reset();
        tick();
        chk("to_wait_req", 32'(imem_req), 32'd1);
        repeat (254) tick();
        chk("to_last_wait_fault", 32'(fault), 32'd0);
        chk("to_last_wait_req",   32'(imem_req), 32'd1);
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req",   32'(imem_req), 32'd0);
        imem_ack  = 1'b1;
        imem_data = mk(7'd0, 4'd1, 4'd1, 4'd1, 16'h0);
        badc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req || !fault || alu_en || wr_en) badc++;
        end
        imem_ack = 1'b0;
        chk("to_sticky", 32'(badc), 32'd0);

        // Halt is terminal.
        do_reset();
        run_instr(mk(7'd2, 4'd4, 4'd4, 4'd4, 16'h0), 0, 1'b0, 1'b0, 32'h0);
        run_instr(mk(7'd127, 4'd0, 4'd0, 4'd0, 16'h0), 1, 1'b0, 1'b1, 32'h80);
        imem_ack = 1'b1;
        badc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_req || !halted || alu_en || wr_en || fault) badc++;
        end
        imem_ack = 1'b0;
        chk("halt_sticky", 32'(badc), 32'd0);
        chk("halt_pc_hold", pc_out, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
